// File: rtl/cpu_call_stack.sv
// Hardware return-address stack with zero-latency top-of-stack read and an
// overflow/underflow fault FSM. Define CALL_STACK_WRAP_EN for circular-buffer overflow.
module cpu_call_stack #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PUSH,
  input  logic              POP,
  input  logic [AWIDTH-1:0] PC_IN,
  input  logic              CLR_FAULT,
  output logic [AWIDTH-1:0] RET_ADDR,
  output logic [PTR_W:0]    DEPTH_CNT,
  output logic              EMPTY,
  output logic              FULL,
  output logic              HALT,
  output logic [1:0]        FAULT_CODE
);

  localparam int unsigned  CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [1:0]   CODE_NONE = 2'b00;
  localparam logic [1:0]   CODE_OVF  = 2'b01;
  localparam logic [1:0]   CODE_UNF  = 2'b10;

  typedef enum logic {S_NORMAL, S_FAULT} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         code_q, code_d;
  logic [AWIDTH-1:0]  mem_q [DEPTH];
  logic [AWIDTH-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_c;
  logic               empty_c;
  logic               full_c;

  assign rd_ptr_c = wp_q - PTR_W'(1);
  assign empty_c  = (cnt_q == '0);
  assign full_c   = (cnt_q == CNT_MAX);

  // Next-state, pointer and storage update
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    mem_d   = mem_q;
    case (state_q)
      S_NORMAL: begin
        if (PUSH && POP && !empty_c) begin
          mem_d[rd_ptr_c] = PC_IN;
        end else if (PUSH) begin
          if (!full_c) begin
            mem_d[wp_q] = PC_IN;
            wp_d        = wp_q + PTR_W'(1);
            cnt_d       = cnt_q + CNT_W'(1);
          end else begin
`ifdef CALL_STACK_WRAP_EN
            // Oldest entry sits at wp when full; overwrite it, count saturates
            mem_d[wp_q] = PC_IN;
            wp_d        = wp_q + PTR_W'(1);
`else
            state_d = S_FAULT;
            code_d  = CODE_OVF;
`endif
          end
        end else if (POP) begin
          if (!empty_c) begin
            wp_d  = wp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_FAULT;
            code_d  = CODE_UNF;
          end
        end
      end
      S_FAULT: begin
        if (CLR_FAULT) begin
          state_d = S_NORMAL;
          wp_d    = '0;
          cnt_d   = '0;
          code_d  = CODE_NONE;
        end
      end
      default: state_d = S_NORMAL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_NORMAL;
      wp_q    <= '0;
      cnt_q   <= '0;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset term
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign RET_ADDR   = empty_c ? '0 : mem_q[rd_ptr_c];
  assign DEPTH_CNT  = cnt_q;
  assign EMPTY      = empty_c;
  assign FULL       = full_c;
  assign HALT       = (state_q == S_FAULT);
  assign FAULT_CODE = code_q;

endmodule

// File: tb/tb_cpu_call_stack.sv
// Scoreboard bench for cpu_call_stack: a queue-based stack model predicts outputs,
// a monitor compares them each cycle. Honours CALL_STACK_WRAP_EN like the design.
module tb_cpu_call_stack;

  localparam int unsigned AWIDTH = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;

  typedef struct packed {
    logic [AWIDTH-1:0] ret;
    logic [PTR_W:0]    cnt;
    logic              empty;
    logic              full;
    logic              halt;
    logic [1:0]        code;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [AWIDTH-1:0] pc_in = '0;
  logic              clr_fault = 1'b0;
  logic [AWIDTH-1:0] ret_addr;
  logic [PTR_W:0]    depth_cnt;
  logic              empty;
  logic              full;
  logic              halt;
  logic [1:0]        fault_code;

  int vectors = 0;
  int miscompares = 0;

  exp_t exp_q[$];

  // Reference model: plain queue of addresses, back is top of stack
  int unsigned stk[$];
  bit          m_fault = 1'b0;
  logic [1:0]  m_code = 2'b00;
  bit          m_known = 1'b0;

  cpu_call_stack #(.AWIDTH(AWIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(clk), .RST(rst), .PUSH(push), .POP(pop), .PC_IN(pc_in),
    .CLR_FAULT(clr_fault), .RET_ADDR(ret_addr), .DEPTH_CNT(depth_cnt),
    .EMPTY(empty), .FULL(full), .HALT(halt), .FAULT_CODE(fault_code)
  );

  always #5 clk = ~clk;

  function automatic exp_t predict();
    exp_t e;
    e.ret   = (stk.size() > 0) ? AWIDTH'(stk[stk.size()-1]) : '0;
    e.cnt   = (PTR_W+1)'(stk.size());
    e.empty = (stk.size() == 0);
    e.full  = (stk.size() == DEPTH);
    e.halt  = m_fault;
    e.code  = m_code;
    return e;
  endfunction

  task automatic model_edge(input bit r, input bit pu, input bit po,
                            input int unsigned pc, input bit clr);
    if (r) begin
      stk.delete(); m_fault = 1'b0; m_code = 2'b00; m_known = 1'b1;
    end else if (!m_known) begin
      // state unknown until the first reset
    end else if (m_fault) begin
      if (clr) begin stk.delete(); m_fault = 1'b0; m_code = 2'b00; end
    end else if (pu && po && stk.size() > 0) begin
      stk[stk.size()-1] = pc;
    end else if (pu) begin
      if (stk.size() < DEPTH) stk.push_back(pc);
      else begin
`ifdef CALL_STACK_WRAP_EN
        void'(stk.pop_front());
        stk.push_back(pc);
`else
        m_fault = 1'b1; m_code = 2'b01;
`endif
      end
    end else if (po) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else begin m_fault = 1'b1; m_code = 2'b10; end
    end
  endtask

  // Drive one cycle; expectation reflects state before the coming edge
  task automatic step(input bit r, input bit pu, input bit po,
                      input int unsigned pc, input bit clr);
    @(posedge clk);
    #1;
    rst = r; push = pu; pop = po; pc_in = AWIDTH'(pc); clr_fault = clr;
    if (m_known) exp_q.push_back(predict());
    model_edge(r, pu, po, pc, clr);
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle and compared with the scoreboard head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ret_addr",   int'(ret_addr),   int'(e.ret));
      check("depth_cnt",  int'(depth_cnt),  int'(e.cnt));
      check("empty",      int'(empty),      int'(e.empty));
      check("full",       int'(full),       int'(e.full));
      check("halt",       int'(halt),       int'(e.halt));
      check("fault_code", int'(fault_code), int'(e.code));
    end
  end

  task automatic idle(); step(0, 0, 0, 0, 0); endtask
  task automatic do_push(input int unsigned pc); step(0, 1, 0, pc, 0); endtask
  task automatic do_pop(); step(0, 0, 1, 0, 0); endtask
  task automatic do_clr(); step(0, 0, 0, 0, 1); endtask
  task automatic do_reset(); step(1, 0, 0, 0, 0); endtask

  initial begin
    int unsigned r;
    bit          pu, po, cl, rs;

    do_reset(); idle();

    // Nested calls and returns
    do_push(8'h10); do_push(8'h20); do_push(8'h30); idle();
    do_pop(); do_pop(); do_pop(); idle();

    // Overflow (wraps instead when the wrap feature is on)
    for (int i = 1; i <= 5; i++) do_push(i);
    idle(); do_pop(); idle(); do_clr(); idle();
    do_reset(); idle();

    // Underflow, then push ignored while halted
    do_pop(); idle(); do_push(8'h77); idle(); do_clr(); idle();

    // Simultaneous push+pop on non-empty and empty stack
    do_push(8'h40); step(0, 1, 1, 8'h55, 0); idle(); do_pop(); idle();
    step(0, 1, 1, 8'h66, 0); idle(); do_pop(); idle();

    // Deep push run, drain past empty, clear; CLR_FAULT in NORMAL has no effect
    for (int i = 1; i <= 6; i++) do_push(i);
    idle();
    for (int i = 0; i < 5; i++) do_pop();
    idle(); do_clr(); idle(); do_clr(); idle();

    // Reset in the middle of a faulted state with a request pending
    do_push(8'hA1); do_pop(); do_pop(); step(1, 1, 1, 8'hB2, 1); idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = $urandom_range(99);
      pu = (r < 45);
      po = ($urandom_range(99) < 40);
      cl = ($urandom_range(99) < 25);
      rs = ($urandom_range(199) == 0);
      step(rs, pu, po, $urandom_range(255), cl);
    end
    idle(); idle();

    @(posedge clk); #1;
    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_call_stack.md
Name: cpu_call_stack

Overview:
- Hardware return-address stack for the one-cycle CPU. Replaces the single link register.
- The decoder's link-register load strobe (CALL) pushes the current PC; the RET decode pops.
- The popped address is driven combinationally back to the PC's JMP_MODE 2'b11 source, so the return completes in the same cycle.
- A small fault state machine halts the PC on stack overflow or underflow until software or the bench clears it.

Parameters:
- AWIDTH, 8, width of a PC/return address (matches the 8-bit operand field).
- DEPTH, 4, number of stack entries (power of two, ≥2).
- PTR_W, 2, log2(DEPTH); the depth counter is PTR_W+1 bits.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- PUSH  input  1  push request (driven by decoder LR_LD)
- POP  input  1  pop request (RET decoded)
- PC_IN  input  AWIDTH  current PC value to save on PUSH
- CLR_FAULT  input  1  leave FAULT state and empty the stack
- RET_ADDR  output  AWIDTH  top-of-stack value, combinational
- DEPTH_CNT  output  PTR_W+1  number of valid entries, 0..DEPTH
- EMPTY  output  1  DEPTH_CNT==0
- FULL  output  1  DEPTH_CNT==DEPTH
- HALT  output  1  high while in FAULT; PC must hold
- FAULT_CODE  output  2  00 none, 01 overflow, 10 underflow

Behaviour:
- Reset (RST high at edge):
  - DEPTH_CNT=0, EMPTY=1, FULL=0, HALT=0, FAULT_CODE=00, state NORMAL.
  - Storage contents are don't-care; RET_ADDR=0 while EMPTY.
- Storage: DEPTH x AWIDTH register array, write pointer wp, read pointer = wp-1 (mod DEPTH).
- RET_ADDR = entry[wp-1] when not EMPTY, else 0. It is valid in the same cycle POP is asserted (zero latency). The pop takes effect at the following edge.
- PC_IN is stored unmodified; the +1 return offset is applied by the PC path.
- States: NORMAL, FAULT.
- NORMAL, per edge:
  - PUSH only, not FULL: entry[wp]<=PC_IN, wp++, DEPTH_CNT++.
  - PUSH only, FULL: the push is dropped, go to FAULT, FAULT_CODE<=01.
  - POP only, not EMPTY: wp--, DEPTH_CNT--.
  - POP only, EMPTY: go to FAULT, FAULT_CODE<=10.
  - PUSH and POP together, not EMPTY: entry[wp-1]<=PC_IN (top replaced), DEPTH_CNT unchanged.
  - PUSH and POP together, EMPTY: treated as PUSH only.
  - Neither: hold.
- FAULT:
  - HALT=1; PUSH and POP are ignored; FAULT_CODE holds.
  - CLR_FAULT at an edge: go to NORMAL, DEPTH_CNT<=0, wp<=0, FAULT_CODE<=00.
- CLR_FAULT in NORMAL: no effect.
- RST has priority over CLR_FAULT and over all requests. Reset in the middle of any sequence returns to the reset values on the next edge.
- Pointer arithmetic wraps modulo DEPTH. DEPTH_CNT never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: CALL_STACK_WRAP_EN
- Defined:
  - The stack is a circular buffer. PUSH when FULL overwrites the oldest entry (entry[wp]<=PC_IN, wp++).
  - DEPTH_CNT saturates at DEPTH. No fault; FAULT_CODE 01 is never produced.
  - Underflow still faults (code 10).
- Not defined: overflow faults as described in Behaviour.

Test Plan:
- Reset then idle: RST=1 for one cycle → DEPTH_CNT=0, EMPTY=1, HALT=0, FAULT_CODE=00, RET_ADDR=0.
- Nested calls:
  - PUSH PC_IN=0x10, 0x20, 0x30 → DEPTH_CNT=3, RET_ADDR=0x30.
  - Three POPs → RET_ADDR reads 0x30, then 0x20, then 0x10 in the POP cycles; then EMPTY=1.
- Overflow (macro undefined):
  - PUSH 0x01..0x04, then PUSH 0x05 → FULL=1, next edge HALT=1, FAULT_CODE=01, RET_ADDR=0x04.
  - A following POP is ignored.
  - CLR_FAULT → HALT=0, EMPTY=1.
- Underflow: POP with EMPTY=1 → HALT=1, FAULT_CODE=10; PUSH while halted is ignored (DEPTH_CNT stays 0).
- Simultaneous PUSH+POP:
  - With 0x40 on top, PUSH+POP with PC_IN=0x55 → DEPTH_CNT unchanged, RET_ADDR=0x55.
  - On an empty stack, PUSH+POP with PC_IN=0x66 → DEPTH_CNT=1, RET_ADDR=0x66.
- Wrap (CALL_STACK_WRAP_EN defined):
  - PUSH 0x01..0x06 → DEPTH_CNT=4, HALT=0.
  - Four POPs return 0x06, 0x05, 0x04, 0x03.
  - A fifth POP → FAULT_CODE=10.
